arm_mc_controller: RTL and testbench
====================================

# arm_mc_controller

Multicycle control FSM for the ARM datapath: it replaces the single-cycle `ControlUnit` decode with a sequenced controller. Each instruction is fetched once, decoded, then driven through its execute, memory and write-back steps over 3–5 cycles. The block holds the architectural NZCV flags and evaluates the condition field. It sits between the instruction register and the shared memory, ALU and register-file datapath.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high
- Instr  in  20  instruction bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  in  4  NZCV from the ALU in the current cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = ReadData, 10 = ALUResult
- ALUSrcA  out  1  ALU A select: 0 = Rn, 1 = PC
- ALUSrcB  out  2  ALU B select: 00 = Rm/Rd, 01 = ExtImm, 10 = constant 4
- ImmSrc  out  2  equal to Op
- RegSrc  out  2  bit0 = branch (R15 as Rn), bit1 = store (Rd as second read)
- RegWrite  out  1  register file write enable
- ALUControl  out  2  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- **Transitions:**
  - FETCH → DECODE.
  - DECODE: Op=01 → MEMADR; Op=00 with Funct[5]=0 → EXECR; Op=00 with Funct[5]=1 → EXECI; Op=10 → BRANCH; Op=11 → FETCH (undefined, no side effects).
  - MEMADR → MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD → MEMWB.
  - EXECR and EXECI → ALUWB.
  - MEMWB, MEMWR, ALUWB and BRANCH → FETCH.
- **Outputs by state** (every unlisted output is 0):
  - FETCH: IRWrite=1, PCWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01, ADD.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=CondEx.
  - MEMWR: AdrSrc=1, MemWrite=CondEx.
  - EXECR: ALUSrcB=00, decoded ALU operation.
  - EXECI: ALUSrcB=01, decoded ALU operation.
  - ALUWB: ResultSrc=00, RegWrite=CondEx.
  - BRANCH: ALUSrcB=01, ResultSrc=10, ADD, PCWrite=CondEx.
- **Writes to R15:** in MEMWB or ALUWB with Rd=15, PCWrite additionally equals CondEx.
- **ALU decode** (EXECR/EXECI only) from Funct[4:1]: 0100 = ADD, 0010 = SUB, 0000 = AND, 1100 = ORR; any other value = ADD.
- **Flags:**
  - Updated only in EXECR/EXECI when CondEx=1 and Funct[0]=1.
  - NZ always update; CV update only for ADD or SUB.
  - Reset value is 0000.
- **Condition check:**
  - Evaluated on the stored flags; CondEx is latched at the end of DECODE.
  - Codes 0000–1101 follow the standard ARM conditions.
  - 1110 (AL) gives 1; 1111 gives 0.

## Timing
- Cycle counts: LDR = 5, STR = 4, data-processing = 4, B = 3. The PC+4 write always happens in FETCH, regardless of CondEx.
- Reset behaviour:
  - While reset is high, the state is forced to FETCH next cycle.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - The other outputs take their FETCH values.
  - Flags and CondEx are cleared.
- Reset mid-instruction aborts it with no register, memory or flag write; the first fetch occurs in the cycle after reset deasserts.
- A failed condition still walks every state of the instruction; it only suppresses writes.
- Flags written in EXECx become visible to the next instruction's DECODE.

## Structure
- Shared package `arm_mc_pkg` holds:
  - the state enum;
  - the ResultSrc, ALUSrcB and ALUControl encodings;
  - the Op codes;
  - the condition-code constants.
- Sub-module `cond_check`: combinational Cond + flags → CondEx.

## Test plan
- ADD R0,R0,#42 (Instr=0xE2800) → states FETCH, DECODE, EXECI, ALUWB; RegWrite=1 only in cycle 4, ALUControl=00, ALUSrcB=01.
- LDR R1,[R0,#4] (0xE5901) → 5 cycles, AdrSrc=1 in MEMRD, RegWrite in MEMWB with ResultSrc=01, MemWrite never 1.
- STR R1,[R0,#4] (0xE5801) → 4 cycles, MemWrite=1 only in MEMWR, RegSrc=10 during DECODE/MEMADR, RegWrite never 1.
- SUBS R2,R1,R1 with ALUFlags=0100, then BEQ (0x0A000) → PCWrite=1 in BRANCH. The same sequence followed by BNE (0x1A000) → PCWrite=0 in BRANCH.
- Reset asserted during MEMRD of LDR → next state FETCH, no RegWrite. After release: IRWrite=1 and PCWrite=1 in the first cycle.
- ADDEQ R3,R3,R3 with Z=0 (0x00833) → passes EXECR and ALUWB with RegWrite=0; the flags are unchanged.

Source files
------------

// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  // Result mux select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU operations
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Instruction classes (Op field)
  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Data-processing command (Funct[4:1]) to ALU operation; unknown commands add.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      4'b0100: alu_decode = ALU_ADD;
      4'b0010: alu_decode = ALU_SUB;
      4'b0000: alu_decode = ALU_AND;
      4'b1100: alu_decode = ALU_ORR;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/arm_mc_controller_cond_check.sv
// Combinational evaluation of the ARM condition field against stored NZCV.
module cond_check (
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);
  import arm_mc_pkg::*;

  logic n_flag;
  logic z_flag;
  logic c_flag;
  logic v_flag;

  assign {n_flag, z_flag, c_flag, v_flag} = Flags;

  // Standard ARM condition table; NV never executes.
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z_flag;
      COND_NE: CondEx = ~z_flag;
      COND_CS: CondEx = c_flag;
      COND_CC: CondEx = ~c_flag;
      COND_MI: CondEx = n_flag;
      COND_PL: CondEx = ~n_flag;
      COND_VS: CondEx = v_flag;
      COND_VC: CondEx = ~v_flag;
      COND_HI: CondEx = c_flag & ~z_flag;
      COND_LS: CondEx = ~c_flag | z_flag;
      COND_GE: CondEx = (n_flag == v_flag);
      COND_LT: CondEx = (n_flag != v_flag);
      COND_GT: CondEx = ~z_flag & (n_flag == v_flag);
      COND_LE: CondEx = z_flag | (n_flag != v_flag);
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control FSM: sequences fetch/decode/execute/memory/write-back,
// holds the NZCV flags and the condition result latched at decode.
module arm_mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ALUControl
);
  import arm_mc_pkg::*;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  state_t     state_reg, state_next;
  logic [3:0] flags_reg, flags_next;
  logic       cond_ex_reg, cond_ex_next;
  logic       cond_ex_now;
  logic [1:0] alu_op;
  logic       in_exec;
  logic       rd_is_pc;

  cond_check u_cond_check (
    .Cond   (cond),
    .Flags  (flags_reg),
    .CondEx (cond_ex_now)
  );

  assign alu_op   = alu_decode(funct[4:1]);
  assign in_exec  = (state_reg == S_EXECR) || (state_reg == S_EXECI);
  assign rd_is_pc = (rd == 4'd15);

  // Immediate format and register-read steering come straight from the instruction.
  assign ImmSrc = op;
  assign RegSrc = {(op == OP_MEM) && !funct[0], op == OP_BR};

  // State, flag and latched-condition registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      flags_reg   <= 4'b0000;
      cond_ex_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      flags_reg   <= flags_next;
      cond_ex_reg <= cond_ex_next;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:   state_next = S_MEMADR;
          OP_DP:    state_next = funct[5] ? S_EXECI : S_EXECR;
          OP_BR:    state_next = S_BRANCH;
          OP_UNDEF: state_next = S_FETCH;
          default:  state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = S_MEMWB;
      S_EXECR:  state_next = S_ALUWB;
      S_EXECI:  state_next = S_ALUWB;
      default:  state_next = S_FETCH;
    endcase
  end

  // Condition is captured once per instruction at decode; flags update only
  // on executed S-suffixed data-processing, with CV limited to add/sub.
  always_comb begin
    cond_ex_next = cond_ex_reg;
    flags_next   = flags_reg;
    if (state_reg == S_DECODE) begin
      cond_ex_next = cond_ex_now;
    end
    if (in_exec && cond_ex_reg && funct[0]) begin
      flags_next[3:2] = ALUFlags[3:2];
      if ((alu_op == ALU_ADD) || (alu_op == ALU_SUB)) begin
        flags_next[1:0] = ALUFlags[1:0];
      end
    end
  end

  // Per-state control outputs; reset presents FETCH steering with writes held off.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    RegWrite   = 1'b0;
    ALUControl = ALU_ADD;
    case (state_reg)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_READDATA;
        RegWrite  = cond_ex_reg;
        PCWrite   = cond_ex_reg & rd_is_pc;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex_reg;
      end
      S_EXECR: begin
        ALUSrcB    = SRCB_REG;
        ALUControl = alu_op;
      end
      S_EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_op;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = cond_ex_reg;
        PCWrite   = cond_ex_reg & rd_is_pc;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        PCWrite   = cond_ex_reg;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = RES_ALURESULT;
      ALUSrcA    = 1'b1;
      ALUSrcB    = SRCB_FOUR;
      RegWrite   = 1'b0;
      ALUControl = ALU_ADD;
    end
  end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Scoreboard bench: the stimulus process runs instructions through a
// behavioural model and queues the expected control word for each cycle;
// the monitor pops one word per cycle and compares it with the DUT.
module tb_arm_mc_controller;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

  arm_mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .ALUControl (ALUControl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Control word layout used by both the model and the monitor.
  logic [15:0] actual;
  assign actual = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                   ALUSrcB, ImmSrc, RegSrc, RegWrite, ALUControl};

  logic [15:0] sb[$];
  logic [15:0] sb_word;
  int          checks = 0;
  int          errors = 0;
  bit          done = 0;

  // Architectural flags as the model sees them.
  bit fn, fz, fc, fv;

  function automatic logic [15:0] mk(input logic [19:0] ins, input bit pcw, input bit adr,
                                     input bit memw, input bit irw, input logic [1:0] rs,
                                     input bit asa, input logic [1:0] asb,
                                     input logic [1:0] aluc, input bit rw);
    logic [1:0] o;
    logic [1:0] rsrc;
    o    = ins[15:14];
    rsrc = {(o == 2'b01) && !ins[8], o == 2'b10};
    return {pcw, adr, memw, irw, rs, asa, asb, o, rsrc, rw, aluc};
  endfunction

  // Condition test written as base predicate plus inversion bit.
  function automatic bit cond_holds(input logic [3:0] c);
    bit r;
    case (c[3:1])
      3'd0: r = fz;
      3'd1: r = fc;
      3'd2: r = fn;
      3'd3: r = fv;
      3'd4: r = fc && !fz;
      3'd5: r = (fn == fv);
      3'd6: r = !fz && (fn == fv);
      default: r = 1'b1;
    endcase
    return c[0] ? !r : r;
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    if (cmd == 4'b0010) return 2'd1;
    if (cmd == 4'b0000) return 2'd2;
    if (cmd == 4'b1100) return 2'd3;
    return 2'd0;
  endfunction

  // Issue one instruction; reset_at >= 0 asserts reset in that cycle and aborts.
  task automatic run_instr(input logic [19:0] ins, input logic [3:0] alu_flags, input int reset_at);
    logic [15:0] seq[$];
    logic [1:0]  o;
    logic [5:0]  f;
    logic [1:0]  aop;
    bit          ce;
    bit          pcwb;
    o    = ins[15:14];
    f    = ins[13:8];
    aop  = alu_of(f[4:1]);
    ce   = cond_holds(ins[19:16]);
    pcwb = ce && (ins[3:0] == 4'd15);
    seq.push_back(mk(ins, 1, 0, 0, 1, 2'd2, 1, 2'd2, 2'd0, 0));
    seq.push_back(mk(ins, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0, 0));
    if (o == 2'b01) begin
      seq.push_back(mk(ins, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, 0));
      if (f[0]) begin
        seq.push_back(mk(ins, 0, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0));
        seq.push_back(mk(ins, pcwb, 0, 0, 0, 2'd1, 0, 2'd0, 2'd0, ce));
      end else begin
        seq.push_back(mk(ins, 0, 1, ce, 0, 2'd0, 0, 2'd0, 2'd0, 0));
      end
    end else if (o == 2'b00) begin
      seq.push_back(mk(ins, 0, 0, 0, 0, 2'd0, 0, f[5] ? 2'd1 : 2'd0, aop, 0));
      seq.push_back(mk(ins, pcwb, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, ce));
    end else if (o == 2'b10) begin
      seq.push_back(mk(ins, ce, 0, 0, 0, 2'd2, 0, 2'd1, 2'd0, 0));
    end
    Instr    = ins;
    ALUFlags = alu_flags;
    $display("instr %05h flags_in=%b cond_ok=%0d cycles=%0d reset_at=%0d",
             ins, alu_flags, ce, seq.size(), reset_at);
    for (int i = 0; i < seq.size(); i++) begin
      if (i == reset_at) begin
        reset = 1'b1;
        sb.push_back(mk(ins, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0, 0));
        @(posedge clk); #1;
        reset = 1'b0;
        {fn, fz, fc, fv} = 4'b0000;
        return;
      end
      sb.push_back(seq[i]);
      @(posedge clk); #1;
    end
    if (o == 2'b00 && ce && f[0]) begin
      fn = alu_flags[3];
      fz = alu_flags[2];
      if (aop == 2'd0 || aop == 2'd1) begin
        fc = alu_flags[1];
        fv = alu_flags[0];
      end
    end
  endtask

  // Monitor: one comparison per cycle while expectations are queued.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_word = sb.pop_front();
      checks++;
      if (actual !== sb_word) begin
        errors++;
        $display("FAIL ctl_word t=%0t actual=%04h required=%04h", $time, actual, sb_word);
      end
    end else if (done) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL sb_drain actual=%0d required=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  // Stimulus: directed test-plan sequences, then randomized instructions.
  initial begin
    logic [19:0] rin;
    logic [1:0]  rop;
    int          rst_at;
    reset    = 1'b1;
    Instr    = 20'h0;
    ALUFlags = 4'h0;
    {fn, fz, fc, fv} = 4'b0000;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(Instr, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0, 0));
      @(posedge clk); #1;
    end
    reset = 1'b0;

    run_instr(20'hE2800, 4'h0, -1);   // ADD R0,R0,#42
    run_instr(20'hE5901, 4'h0, -1);   // LDR R1,[R0,#4]
    run_instr(20'hE5801, 4'h0, -1);   // STR R1,[R0,#4]
    run_instr(20'hE0512, 4'b0100, -1); // SUBS R2,R1,R1 -> Z
    run_instr(20'h0A000, 4'h0, -1);   // BEQ taken
    run_instr(20'hE0512, 4'b0100, -1);
    run_instr(20'h1A000, 4'h0, -1);   // BNE not taken
    run_instr(20'hE5901, 4'h0, 3);    // LDR aborted in MEMRD
    run_instr(20'h00833, 4'hF, -1);   // ADDEQ with Z=0
    run_instr(20'h0A000, 4'h0, -1);   // BEQ still not taken
    run_instr(20'hE281F, 4'h0, -1);   // ADD PC,... writes R15

    for (int n = 0; n < 200; n++) begin
      rin = 20'($urandom);
      rop = 2'($urandom_range(9, 0) < 4 ? 0 : $urandom_range(3, 1));
      rin[15:14] = rop;
      if ($urandom_range(3, 0) == 0) rin[3:0] = 4'hF;
      if ($urandom_range(2, 0) != 0 && rop == 2'b00) rin[8] = 1'b1;
      rst_at = ($urandom_range(29, 0) == 0) ? int'($urandom_range(1, 0)) : -1;
      run_instr(rin, 4'($urandom), rst_at);
    end
    done = 1'b1;
  end

endmodule
